ts_serial_tx: RTL and testbench

- Serial MPEG-TS transmitter: the transmit end of the 4-wire serial TS interface (clock/start/valid/data) that the demodulators drive into the design.
- Accepts a byte stream carrying packet-start marks, e.g. from an EP2 OUT consumer. Emits 188-byte packets MSB-first on a generated TS clock.
- Use: loop-back test of the TS capture path, and feeding the CI CAM TS input.
- Runs entirely in the usb_ulpi_clk domain.

---
 rtl/ts_serial_tx.sv | 139 +++++++++++++
 tb/tb_ts_serial_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_serial_tx.sv
`default_nettype none
// ts_serial_tx: serial MPEG-TS transmitter (clock/start/valid/data lines), PKT_LEN-byte packets
// sent MSB-first behind a one-byte holding register, with underrun stall and a fixed idle gap.
module ts_serial_tx #(
  parameter int HALF_DIV = 2,
  parameter int PKT_LEN  = 188,
  parameter int GAP_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  in_data,
  input  logic        in_start,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ts_clk,
  output logic        ts_data,
  output logic        ts_valid,
  output logic        ts_start,
  output logic        busy,
  output logic [15:0] pkts_cnt,
  output logic [7:0]  drop_cnt
);
  localparam int PH_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state;
  logic [PH_W-1:0]    phase;
  logic               hold_full;
  logic               hold_start;
  logic [7:0]         hold_data;
  logic [7:0]         shreg;
  logic [2:0]         bit_idx;
  logic [IDX_W-1:0]   byte_idx;
  logic [GAP_W-1:0]   gap_cnt;

  logic half_end, slot, idle_eval, byte_eval, pkt_done;
  logic load_first, load_byte, idle_drop, drop_inc;

  // A slot boundary is the cycle in which ts_clk is registered 1->0.
  assign half_end   = (phase == PH_LAST);
  assign slot       = half_end && ts_clk;
  assign idle_eval  = slot && (state == IDLE || (state == GAP && gap_cnt == '0));
  assign byte_eval  = slot && (state == STALL ||
                      (state == SHIFT && bit_idx == 3'd0 && byte_idx != IDX_LAST));
  assign pkt_done   = slot && state == SHIFT && bit_idx == 3'd0 && byte_idx == IDX_LAST;
  assign load_first = idle_eval && hold_full && hold_start && enable;
  assign load_byte  = byte_eval && hold_full;
  assign idle_drop  = (state == IDLE) && hold_full && !hold_start;
  assign drop_inc   = idle_drop || (load_byte && hold_start);

  assign in_ready = ~hold_full;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= '0;
      ts_clk     <= 1'b1;
      ts_data    <= 1'b0;
      ts_valid   <= 1'b0;
      ts_start   <= 1'b0;
      hold_full  <= 1'b0;
      hold_start <= 1'b0;
      hold_data  <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      gap_cnt    <= '0;
      pkts_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      if (half_end) begin
        phase  <= '0;
        ts_clk <= ~ts_clk;
      end else begin
        phase <= phase + PH_W'(1);
      end

      // Fill and empty are exclusive: a fill needs the register empty, a consume needs it full.
      if (in_valid && !hold_full) begin
        hold_full  <= 1'b1;
        hold_data  <= in_data;
        hold_start <= in_start;
      end else if (idle_drop || load_first || load_byte) begin
        hold_full <= 1'b0;
      end

      if (drop_inc && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      if (load_first || load_byte) begin
        state    <= SHIFT;
        shreg    <= {hold_data[6:0], 1'b0};
        ts_data  <= hold_data[7];
        ts_valid <= 1'b1;
        ts_start <= hold_start;
        bit_idx  <= 3'd7;
        byte_idx <= hold_start ? '0 : byte_idx + IDX_W'(1);
      end else if (slot && state == SHIFT && bit_idx != 3'd0) begin
        ts_data  <= shreg[7];
        shreg    <= {shreg[6:0], 1'b0};
        bit_idx  <= bit_idx - 3'd1;
        ts_start <= 1'b0;
      end else if (pkt_done) begin
        state    <= GAP;
        gap_cnt  <= GAP_LAST;
        pkts_cnt <= pkts_cnt + 16'd1;
        ts_valid <= 1'b0;
        ts_data  <= 1'b0;
        ts_start <= 1'b0;
      end else if (byte_eval) begin
        state    <= STALL;
        ts_valid <= 1'b0;
        ts_data  <= 1'b0;
        ts_start <= 1'b0;
      end else if (idle_eval) begin
        state    <= IDLE;
        ts_valid <= 1'b0;
        ts_data  <= 1'b0;
        ts_start <= 1'b0;
      end else if (slot && state == GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ts_serial_tx.sv
`default_nettype none
// Bench for ts_serial_tx: randomized packets are decoded back from the serial lines and
// compared with a packet-level model of what the transmitter must send, drop and count.
module tb_ts_serial_tx;
  localparam int HALF_DIV = 2;
  localparam int PKT_LEN  = 188;
  localparam int GAP_BITS = 8;

  logic        clk = 1'b0;
  logic        reset, enable, in_start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, ts_clk, ts_data, ts_valid, ts_start, busy;
  logic [15:0] pkts_cnt;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  ts_serial_tx #(.HALF_DIV(HALF_DIV), .PKT_LEN(PKT_LEN), .GAP_BITS(GAP_BITS)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_data(in_data), .in_start(in_start), .in_valid(in_valid), .in_ready(in_ready),
    .ts_clk(ts_clk), .ts_data(ts_data), .ts_valid(ts_valid), .ts_start(ts_start),
    .busy(busy), .pkts_cnt(pkts_cnt), .drop_cnt(drop_cnt)
  );

  int checks_total = 0, checks_passed = 0, checks_failed = 0;

  // Reference model: which accepted bytes must appear on the line, plus expected counters.
  logic [8:0] exp_q[$];
  logic [8:0] rx_q[$];
  int m_pkts = 0, m_drop = 0, m_n = 0;

  // Line decoder state, sampled on each rising ts_clk (seen at the falling clk edge).
  int   bitn = 0, valid_slots = 0, idle_run = 0, last_gap = -1, stall_slots = 0, framing_err = 0;
  logic [7:0] cur = 8'h00;
  logic cur_start = 1'b0, prev_tsclk = 1'b1;

  always @(negedge clk) begin
    if (ts_clk && !prev_tsclk) begin
      if (ts_valid) begin
        if (bitn == 0) begin
          cur_start = ts_start;
          if (ts_start) last_gap = idle_run;
          else stall_slots += idle_run;
        end else if (ts_start) begin
          framing_err++;
        end
        cur = {cur[6:0], ts_data};
        bitn++;
        valid_slots++;
        idle_run = 0;
        if (bitn == 8) begin
          rx_q.push_back({cur_start, cur});
          bitn = 0;
        end
      end else begin
        if (bitn != 0 || ts_start) framing_err++;
        idle_run++;
      end
    end
    prev_tsclk = ts_clk;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_push(input logic [7:0] d, input logic s);
    if (s) begin
      if (m_n > 0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      m_n = 1;
      exp_q.push_back({1'b1, d});
    end else if (m_n == 0) begin
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    end else begin
      m_n++;
      exp_q.push_back({1'b0, d});
    end
    if (m_n == PKT_LEN) begin
      m_n = 0;
      m_pkts++;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int   t = 0;
    logic hs = 1'b0;
    in_data  = d;
    in_start = s;
    in_valid = 1'b1;
    forever begin
      hs = in_ready;
      tick();
      if (hs) break;
      if (++t > 400) begin
        check("send_handshake", hs, 1);
        break;
      end
    end
    in_valid = 1'b0;
    if (hs) model_push(d, s);
  endtask

  // Bytes [from, to) of a packet; index 0 carries the start mark and the 0x47 sync byte.
  task automatic send_pkt(input int from, input int to, input int hold_at, input bit det);
    for (int i = from; i < to; i++) begin
      logic [7:0] b;
      if (i == 0) b = 8'h47;
      else if (det) b = 8'(i - 1);
      else b = 8'($urandom);
      if (i == hold_at) repeat (100) tick();
      send(b, i == 0);
    end
  endtask

  task automatic wait_drained(input string tag);
    int done = 0;
    for (int t = 0; t < 2000; t++) begin
      if (rx_q.size() == exp_q.size() && !busy && in_ready) begin
        done = 1;
        break;
      end
      tick();
    end
    check({tag, "_drained"}, done, 1);
  endtask

  task automatic check_stream(input string tag);
    int bad = 0;
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) bad++;
    check({tag, "_bytes_bad"}, bad, 0);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ts_clk"}, ts_clk, 1);
    check({tag, "_ts_data"}, ts_data, 0);
    check({tag, "_ts_valid"}, ts_valid, 0);
    check({tag, "_ts_start"}, ts_start, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pkts"}, pkts_cnt, 0);
    check({tag, "_drop"}, drop_cnt, 0);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int k, vs0, ss0, pk0;

  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_start = 1'b0;
    repeat (3) tick();
    check_reset_state("reset");

    reset = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (ts_clk && k < 20);
    check("first_ts_clk_fall", k, HALF_DIV);

    // Two back-to-back packets: deterministic 0x47,0x00..0xBA then random payload.
    vs0 = valid_slots;
    send_pkt(0, PKT_LEN, -1, 1'b1);
    send_pkt(0, PKT_LEN, -1, 1'b0);
    wait_drained("b2b");
    check("b2b_valid_slots", valid_slots - vs0, 2 * PKT_LEN * 8);
    check("b2b_gap_slots", last_gap, GAP_BITS);
    check("b2b_pkts", pkts_cnt, m_pkts);
    check("b2b_drop", drop_cnt, m_drop);
    check_stream("b2b");

    // Underrun: byte 10 withheld for 100 cycles.
    ss0 = stall_slots;
    send_pkt(0, PKT_LEN, 10, 1'b0);
    wait_drained("stall");
    k = stall_slots - ss0;
    check("stall_slots_in_range", (k >= 5 && k <= 25), 1);
    check("stall_pkts", pkts_cnt, m_pkts);
    check("stall_drop", drop_cnt, m_drop);
    check_stream("stall");

    // Non-start bytes while idle are discarded, then a normal packet follows.
    vs0 = valid_slots;
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    wait_drained("junk");
    check("junk_drop", drop_cnt, m_drop);
    check("junk_no_valid", valid_slots - vs0, 0);
    send_pkt(0, PKT_LEN, -1, 1'b0);
    wait_drained("after_junk");
    check("after_junk_pkts", pkts_cnt, m_pkts);
    check_stream("after_junk");

    // Truncation: a start mark on byte 100 restarts the packet.
    pk0 = m_pkts;
    send_pkt(0, 100, -1, 1'b0);
    send_pkt(0, 50, -1, 1'b0);
    check("trunc_mid_pkts", pkts_cnt, pk0);
    check("trunc_mid_drop", drop_cnt, m_drop);
    send_pkt(50, PKT_LEN, -1, 1'b0);
    wait_drained("trunc");
    check("trunc_pkts", pkts_cnt, m_pkts);
    check("trunc_drop", drop_cnt, m_drop);
    check_stream("trunc");

    // enable=0 holds a queued start byte.
    enable = 1'b0;
    vs0 = valid_slots;
    send(8'h47, 1'b1);
    repeat (60) tick();
    check("en0_in_ready", in_ready, 0);
    check("en0_busy", busy, 0);
    check("en0_no_valid", valid_slots - vs0, 0);
    enable = 1'b1;
    send_pkt(1, PKT_LEN, -1, 1'b0);
    wait_drained("en1");
    check("en1_pkts", pkts_cnt, m_pkts);
    check_stream("en1");

    // Reset in the middle of a packet.
    send_pkt(0, 50, -1, 1'b0);
    reset = 1'b1;
    tick();
    check_reset_state("midreset");
    rx_q.delete(); exp_q.delete();
    m_pkts = 0; m_drop = 0; m_n = 0;
    bitn = 0; idle_run = 0;
    reset = 1'b0;

    // drop_cnt saturation.
    for (int i = 0; i < 300; i++) send(8'($urandom), 1'b0);
    wait_drained("sat");
    check("sat_drop", drop_cnt, m_drop);
    check("sat_drop_ff", drop_cnt, 8'hFF);
    check("sat_pkts", pkts_cnt, 0);
    check("framing_errors", framing_err, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
`default_nettype wire
